// File: rtl/norm_24bits.sv
// Two-stage pipelined 24-bit mantissa normalizer with valid/ready flow control.
// Define NORM_SUBNORMAL_EN for gradual underflow; otherwise underflows flush to zero.
module norm_24bits #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_sub
);

  localparam int CW = (EXP_W > 5) ? EXP_W : 5;

  // Leading-zero count: six nibble counters feeding a group priority encoder.
  logic [5:0] grp_nz;
  logic [1:0] grp_lz [6];
  logic [4:0] lz;

  for (genvar g = 0; g < 6; g++) begin : g_grp
    logic [3:0] nib;
    assign nib       = in_mant[23-4*g -: 4];
    assign grp_nz[g] = |nib;
    assign grp_lz[g] = nib[3] ? 2'd0 :
                       nib[2] ? 2'd1 :
                       nib[1] ? 2'd2 : 2'd3;
  end

  always_comb begin
    lz = 5'd24;
    // Scan from the least significant group so the most significant nonzero group wins.
    for (int g = 5; g >= 0; g--) begin
      if (grp_nz[g]) lz = 5'(4 * g) + {3'b000, grp_lz[g]};
    end
  end

  logic             s1_valid;
  logic [23:0]      s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [4:0]       s1_lz;

  logic s1_accept, s2_load;

  assign in_ready  = ~s1_valid | ~out_valid | out_ready;
  assign s1_accept = in_valid & in_ready;
  assign s2_load   = s1_valid & (~out_valid | out_ready);

  // Normalization of the S1 operand, registered into S2.
  logic [CW-1:0]    exp_ext, lz_ext;
  logic [23:0]      n_mant;
  logic [EXP_W-1:0] n_exp;
  logic             n_zero;

  assign exp_ext = CW'(s1_exp);
  assign lz_ext  = CW'(s1_lz);

`ifdef NORM_SUBNORMAL_EN
  logic       n_sub;
  logic [4:0] sub_shift;

  // Only used when s1_exp <= s1_lz <= 23, so the shift always fits in 5 bits.
  assign sub_shift = (s1_exp == '0) ? 5'd0 : 5'(s1_exp - 1'b1);
`endif

  always_comb begin
    n_mant = '0;
    n_exp  = '0;
    n_zero = 1'b0;
`ifdef NORM_SUBNORMAL_EN
    n_sub  = 1'b0;
`endif
    if (s1_mant == '0) begin
      n_zero = 1'b1;
    end else if (exp_ext > lz_ext) begin
      n_exp  = s1_exp - EXP_W'(s1_lz);
      n_mant = s1_mant << s1_lz;
    end else begin
`ifdef NORM_SUBNORMAL_EN
      n_sub  = 1'b1;
      n_mant = s1_mant << sub_shift;
`else
      n_zero = 1'b1;
`endif
    end
  end

  // NOTE: nonblocking (<=) so both stages sample pre-edge values and advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_lz     <= '0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (s1_accept) begin
        s1_valid <= 1'b1;
        s1_mant  <= in_mant;
        s1_exp   <= in_exp;
        s1_lz    <= lz;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        out_mant  <= n_mant;
        out_exp   <= n_exp;
        out_zero  <= n_zero;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef NORM_SUBNORMAL_EN
  always_ff @(posedge clk) begin
    if (rst)          out_sub <= 1'b0;
    else if (s2_load) out_sub <= n_sub;
  end
`else
  assign out_sub = 1'b0;
`endif

endmodule
